sccb_master: RTL and testbench

SCCB (I2C-compatible) write master for the OV7670 camera. It sits directly downstream of the camera register-configuration sequencer: it accepts one register address/data pair per `start` pulse and serialises it onto SIOC/SIOD as a 3-phase write to the camera. It returns `ready` when the bus is free for the next command. SIOC/SIOD are open-drain; the block only drives output-enables, and the pad logic pulls the line low when an enable is 1.

---
 rtl/sccb_master_if.sv | 23 ++
 rtl/sccb_master.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_sccb_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_master_if.sv
// sccb_master_if: command handshake and open-drain bus signals of the SCCB write master.
// master modport is the block's own view; slave modport is the sequencer/pad/bench side.
interface sccb_master_if;
  logic       start;
  logic [7:0] address;
  logic [7:0] data;
  logic       rw;
  logic       SIOD_in;
  logic       ready;
  logic [7:0] read_data;
  logic       SIOC_oe;
  logic       SIOD_oe;

  modport master (
    input  start, address, data, rw, SIOD_in,
    output ready, read_data, SIOC_oe, SIOD_oe
  );

  modport slave (
    output start, address, data, rw, SIOD_in,
    input  ready, read_data, SIOC_oe, SIOD_oe
  );
endinterface

// File: rtl/sccb_master.sv
// sccb_master: SCCB (I2C-compatible) master for the OV7670 configuration path.
// Accepts one address/data pair per start pulse and serialises it as a 3-phase write.
// Optional feature macro: SCCB_READ_EN enables 2-phase-write + 2-phase-read register reads.
// Every bus segment lasts one quarter SIOC period (QTR clocks); outputs are registered
// from the next-state decode so the open-drain enables never glitch.
module sccb_master #(
  parameter int         CLK_FREQ    = 25000000,
  parameter int         SCCB_FREQ   = 100000,
  parameter logic [7:0] CAMERA_ADDR = 8'h42
) (
  input  logic          clk,
  input  logic          rst,
  sccb_master_if.master bus
);
  localparam int QTR_RAW = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QTR     = (QTR_RAW < 1) ? 1 : QTR_RAW;
  localparam int CW      = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] QTR_LAST = CW'(QTR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TX,
    S_STOP,
    S_BUS_FREE
`ifdef SCCB_READ_EN
    , S_RX
`endif
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic          w_accept;
  logic [1:0]    r_phase, w_phase_next;   // quarter within a bit, or step within START/STOP/BUS_FREE
  logic [3:0]    r_bit, w_bit_next;       // 0..7 data bits, 8 = ack/nack slot
  logic [1:0]    r_byte, w_byte_next;     // byte index within the current frame
  logic [7:0]    r_addr, r_data;
  logic          r_ready, w_ready_next;
  logic          r_sioc_oe, w_sioc_oe_next;
  logic          r_siod_oe, w_siod_oe_next;
  logic          w_last_byte;
  logic [7:0]    w_tx_byte;
  logic [2:0]    w_bit_sel;

`ifdef SCCB_READ_EN
  logic          r_rw;
  logic          r_second, w_second_next;     // 1 = second (read) frame of a read command
  logic [7:0]    r_rx_shift, w_rx_shift_next;
  logic [7:0]    r_read_data, w_read_data_next;
`else
  logic          w_unused;
  assign w_unused = &{1'b0, bus.rw, bus.SIOD_in};
`endif

  assign w_tick    = (r_cnt == QTR_LAST);
  assign w_bit_sel = 3'd7 - w_bit_next[2:0];

  // quarter-period divider, realigned to the command so the first segment is a full QTR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // command fields are captured only on acceptance and held for the whole transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= 8'h00;
      r_data <= 8'h00;
    end else if (w_accept) begin
      r_addr <= bus.address;
      r_data <= bus.data;
    end
  end

  // FSM state, position counters and registered bus enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_phase   <= 2'd0;
      r_bit     <= 4'd0;
      r_byte    <= 2'd0;
      r_ready   <= 1'b1;
      r_sioc_oe <= 1'b0;
      r_siod_oe <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_phase   <= w_phase_next;
      r_bit     <= w_bit_next;
      r_byte    <= w_byte_next;
      r_ready   <= w_ready_next;
      r_sioc_oe <= w_sioc_oe_next;
      r_siod_oe <= w_siod_oe_next;
    end
  end

`ifdef SCCB_READ_EN
  // read-path registers: direction, frame half, receive shifter and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw        <= 1'b0;
      r_second    <= 1'b0;
      r_rx_shift  <= 8'h00;
      r_read_data <= 8'h00;
    end else begin
      if (w_accept) r_rw <= bus.rw;
      r_second    <= w_second_next;
      r_rx_shift  <= w_rx_shift_next;
      r_read_data <= w_read_data_next;
    end
  end
`endif

  // next-state logic; every phase advance happens on a divider tick
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_bit_next   = r_bit;
    w_byte_next  = r_byte;
    w_ready_next = r_ready;
    w_accept     = 1'b0;
    w_last_byte  = (r_byte == 2'd2);
`ifdef SCCB_READ_EN
    w_second_next    = r_second;
    w_rx_shift_next  = r_rx_shift;
    w_read_data_next = r_read_data;
    if (r_rw) w_last_byte = r_second ? (r_byte == 2'd0) : (r_byte == 2'd1);
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_START;
          w_phase_next = 2'd0;
          w_ready_next = 1'b0;
`ifdef SCCB_READ_EN
          w_second_next = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_phase == 2'd1) begin
            w_state_next = S_TX;
            w_phase_next = 2'd0;
            w_bit_next   = 4'd0;
            w_byte_next  = 2'd0;
          end else begin
            w_phase_next = r_phase + 2'd1;
          end
        end
      end
      S_TX: begin
        if (w_tick) begin
          w_phase_next = r_phase + 2'd1;
          if (r_phase == 2'd3) begin
            if (r_bit == 4'd8) begin
              w_bit_next = 4'd0;
              if (w_last_byte) begin
`ifdef SCCB_READ_EN
                w_state_next = (r_rw && r_second) ? S_RX : S_STOP;
`else
                w_state_next = S_STOP;
`endif
              end else begin
                w_byte_next = r_byte + 2'd1;
              end
            end else begin
              w_bit_next = r_bit + 4'd1;
            end
          end
        end
      end
`ifdef SCCB_READ_EN
      S_RX: begin
        if (w_tick) begin
          w_phase_next = r_phase + 2'd1;
          // sample at the end of the first SIOC-high quarter, well inside the high time
          if ((r_phase == 2'd2) && (r_bit < 4'd8)) w_rx_shift_next = {r_rx_shift[6:0], bus.SIOD_in};
          if (r_phase == 2'd3) begin
            if (r_bit == 4'd8) begin
              w_bit_next       = 4'd0;
              w_state_next     = S_STOP;
              w_read_data_next = r_rx_shift;
            end else begin
              w_bit_next = r_bit + 4'd1;
            end
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_phase == 2'd2) begin
            w_state_next = S_BUS_FREE;
            w_phase_next = 2'd0;
          end else begin
            w_phase_next = r_phase + 2'd1;
          end
        end
      end
      S_BUS_FREE: begin
        if (w_tick) begin
          if (r_phase == 2'd1) begin
            w_phase_next = 2'd0;
`ifdef SCCB_READ_EN
            if (r_rw && !r_second) begin
              w_state_next  = S_START;
              w_second_next = 1'b1;
            end else begin
              w_state_next = S_IDLE;
              w_ready_next = 1'b1;
            end
`else
            w_state_next = S_IDLE;
            w_ready_next = 1'b1;
`endif
          end else begin
            w_phase_next = r_phase + 2'd1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_ready_next = 1'b1;
      end
    endcase
  end

  // bus enable decode for the segment about to start
  always_comb begin
    w_tx_byte      = CAMERA_ADDR;
    w_sioc_oe_next = 1'b0;
    w_siod_oe_next = 1'b0;
    case (w_byte_next)
      2'd1:    w_tx_byte = r_addr;
      2'd2:    w_tx_byte = r_data;
      default: w_tx_byte = CAMERA_ADDR;
    endcase
`ifdef SCCB_READ_EN
    if (w_second_next && (w_byte_next == 2'd0)) w_tx_byte = CAMERA_ADDR | 8'h01;
`endif
    case (w_state_next)
      S_START: begin
        w_siod_oe_next = 1'b1;
        w_sioc_oe_next = (w_phase_next == 2'd1);
      end
      S_TX: begin
        w_sioc_oe_next = (w_phase_next < 2'd2);
        if (w_bit_next < 4'd8) w_siod_oe_next = ~w_tx_byte[w_bit_sel];
      end
`ifdef SCCB_READ_EN
      S_RX: begin
        w_sioc_oe_next = (w_phase_next < 2'd2);
      end
`endif
      S_STOP: begin
        w_sioc_oe_next = (w_phase_next == 2'd0);
        w_siod_oe_next = (w_phase_next != 2'd2);
      end
      default: begin
        w_sioc_oe_next = 1'b0;
        w_siod_oe_next = 1'b0;
      end
    endcase
  end

  assign bus.ready   = r_ready;
  assign bus.SIOC_oe = r_sioc_oe;
  assign bus.SIOD_oe = r_siod_oe;
`ifdef SCCB_READ_EN
  assign bus.read_data = r_read_data;
`else
  assign bus.read_data = 8'h00;
`endif
endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: randomized self-checking bench for sccb_master.
// A line monitor decodes the open-drain wires into START/byte/STOP tokens; a frame-level
// model predicts the token list, ready-low time and read_data for each command.
module tb_sccb_master;
  localparam int         CLK_FREQ  = 25000000;
  localparam int         SCCB_FREQ = 100000;
  localparam logic [7:0] CAM       = 8'h42;
  localparam int         QTR_RAW   = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int         QTR       = (QTR_RAW < 1) ? 1 : QTR_RAW;
  localparam int         TOK_S     = 256;
  localparam int         TOK_P     = 512;
  localparam logic [7:0] SLAVE_RD  = 8'h76;
  localparam int         WAIT_MAX  = 12000;
`ifdef SCCB_READ_EN
  localparam bit READ_BUILD = 1'b1;
`else
  localparam bit READ_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sccb_master_if bus();

  sccb_master #(.CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FREQ), .CAMERA_ADDR(CAM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // monitor / slave state
  int       ev_q[$];
  longint   ev_t[$];
  int       low_q[$];
  longint   cyc = 0;
  bit       prev_scl = 1'b1;
  bit       prev_sda = 1'b1;
  int       bitcnt = 0;
  int       bidx = 0;
  logic [8:0] shreg = '0;
  int       low_run = 0;
  bit       rd_active = 1'b0;
  int       rd_idx = 0;
  logic     slave_sda = 1'b1;

  // model state
  int         exp_q[$];
  int         exp_low_q[$];
  logic [7:0] exp_rd = 8'h00;

  assign bus.SIOD_in = slave_sda & ~bus.SIOD_oe;

  // decode wires at the falling clock edge; slave drives the read byte after the read ID
  always @(negedge clk) begin : mon
    bit scl;
    bit sda;
    cyc++;
    scl = ~bus.SIOC_oe;
    sda = ~bus.SIOD_oe & slave_sda;
    if (rst) begin
      bitcnt = 0; bidx = 0; rd_active = 1'b0; slave_sda = 1'b1; low_run = 0;
    end else begin
      if (scl && prev_scl && (sda != prev_sda)) begin
        ev_q.push_back(sda ? TOK_P : TOK_S);
        ev_t.push_back(cyc);
        bitcnt = 0;
        bidx = 0;
      end else if (scl && !prev_scl) begin
        shreg = {shreg[7:0], sda};
        bitcnt++;
        if (bitcnt == 9) begin
          ev_q.push_back(int'(shreg[8:1]));
          ev_t.push_back(cyc);
          if ((bidx == 0) && (shreg[8:1] == (CAM | 8'h01))) begin
            rd_active = 1'b1;
            rd_idx = 0;
          end
          bitcnt = 0;
          bidx++;
        end
      end else if (!scl && prev_scl && rd_active) begin
        if (rd_idx < 8) slave_sda = SLAVE_RD[7 - rd_idx];
        else begin
          slave_sda = 1'b1;
          rd_active = 1'b0;
        end
        rd_idx++;
      end
      if (bus.ready !== 1'b1) low_run++;
      else if (low_run != 0) begin
        low_q.push_back(low_run);
        low_run = 0;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  function automatic string q_str(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) begin
      int v;
      v = q[i];
      if (v == TOK_S) s = {s, "S "};
      else if (v == TOK_P) s = {s, "P "};
      else s = {s, $sformatf("%02h ", v[7:0])};
    end
    return s;
  endfunction

  // frame-level expectation: token list, ready-low clocks and resulting read_data
  task automatic model_cmd(input logic [7:0] a, input logic [7:0] d, input logic r);
    if (READ_BUILD && r) begin
      exp_q.push_back(TOK_S); exp_q.push_back(CAM); exp_q.push_back(a); exp_q.push_back(TOK_P);
      exp_q.push_back(TOK_S); exp_q.push_back(CAM | 8'h01); exp_q.push_back(SLAVE_RD);
      exp_q.push_back(TOK_P);
      // two frames of 2 bytes each (the received byte plus NACK counts as one byte slot)
      exp_low_q.push_back(((2 + 2 * 36 + 3 + 2) * 2) * QTR);
      exp_rd = SLAVE_RD;
    end else begin
      exp_q.push_back(TOK_S); exp_q.push_back(CAM); exp_q.push_back(a); exp_q.push_back(d);
      exp_q.push_back(TOK_P);
      exp_low_q.push_back((2 + 3 * 36 + 3 + 2) * QTR);
    end
  endtask

  task automatic clear_all();
    ev_q.delete(); ev_t.delete(); low_q.delete(); exp_q.delete(); exp_low_q.delete();
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] d, input logic r);
    @(negedge clk);
    bus.start = 1'b1; bus.address = a; bus.data = d; bus.rw = r;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    n_vec++; if (bus.SIOC_oe !== 1'b0) begin n_err++; $display("FAIL reset_sioc got %b want 0", bus.SIOC_oe); end
    n_vec++; if (bus.SIOD_oe !== 1'b0) begin n_err++; $display("FAIL reset_siod got %b want 0", bus.SIOD_oe); end
    n_vec++; if (bus.read_data !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h want 00", bus.read_data); end
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++; if (bus.ready !== 1'b1 || bus.SIOC_oe !== 1'b0 || bus.SIOD_oe !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset got ready=%b sioc=%b siod=%b want 1 0 0", bus.ready, bus.SIOC_oe, bus.SIOD_oe);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_basic();
    bit ok;
    clear_all();
    model_cmd(8'h12, 8'h80, 1'b0);
    issue(8'h12, 8'h80, 1'b0);
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL write_basic_timeout got busy want ready"); end
    n_vec++; if (q_str(ev_q) != q_str(exp_q)) begin n_err++; $display("FAIL write_basic_frame got %s want %s", q_str(ev_q), q_str(exp_q)); end
    n_vec++; if (low_q.size() != 1 || low_q[0] != 7130 || low_q[0] != exp_low_q[0]) begin
      n_err++; $display("FAIL write_basic_latency got %0d want %0d", (low_q.size() > 0) ? low_q[0] : -1, exp_low_q[0]);
    end
    n_vec++; if (bus.SIOC_oe !== 1'b0 || bus.SIOD_oe !== 1'b0) begin
      n_err++; $display("FAIL write_basic_release got sioc=%b siod=%b want 0 0", bus.SIOC_oe, bus.SIOD_oe);
    end
    $display("write addr=12 data=80 frame=%s ready_low=%0d", q_str(ev_q), (low_q.size() > 0) ? low_q[0] : -1);
  endtask

  task automatic test_ignore_mid();
    bit ok;
    logic [7:0] a, d;
    a = 8'($urandom); d = 8'($urandom);
    clear_all();
    model_cmd(a, d, 1'b0);
    issue(a, d, 1'b0);
    repeat (3000) @(negedge clk);
    bus.start = 1'b1; bus.address = 8'h3A; bus.data = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(ok);
    repeat (300) @(negedge clk);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ignore_mid_timeout got busy want ready"); end
    n_vec++; if (q_str(ev_q) != q_str(exp_q)) begin n_err++; $display("FAIL ignore_mid_frame got %s want %s", q_str(ev_q), q_str(exp_q)); end
    n_vec++; if (low_q.size() != 1 || bus.ready !== 1'b1) begin
      n_err++; $display("FAIL ignore_mid_extra got %0d busy periods ready=%b want 1 period ready=1", low_q.size(), bus.ready);
    end
    $display("write addr=%h data=%h with mid start addr=3A frame=%s", a, d, q_str(ev_q));
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    clear_all();
    model_cmd(8'h11, 8'h01, 1'b0);
    model_cmd(8'h0C, 8'h04, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.address = 8'h11; bus.data = 8'h01; bus.rw = 1'b0;
    k = 0; while (bus.ready !== 1'b0 && k < WAIT_MAX) begin @(negedge clk); k++; end
    bus.address = 8'h0C; bus.data = 8'h04;
    k = 0; while (bus.ready !== 1'b1 && k < WAIT_MAX) begin @(negedge clk); k++; end
    k = 0; while (bus.ready !== 1'b0 && k < WAIT_MAX) begin @(negedge clk); k++; end
    bus.start = 1'b0;
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_timeout got busy want ready"); end
    n_vec++; if (q_str(ev_q) != q_str(exp_q)) begin n_err++; $display("FAIL b2b_frames got %s want %s", q_str(ev_q), q_str(exp_q)); end
    // last STOP quarter + 2 bus-free quarters, then one clock for the acceptance edge
    n_vec++; if (ev_t.size() < 6 || (ev_t[5] - ev_t[4]) != longint'(3 * QTR + 1)) begin
      n_err++; $display("FAIL b2b_gap got %0d want %0d", (ev_t.size() >= 6) ? (ev_t[5] - ev_t[4]) : -1, 3 * QTR + 1);
    end
    n_vec++; if (low_q.size() != 2 || low_q[0] != exp_low_q[0] || low_q[1] != exp_low_q[1]) begin
      n_err++; $display("FAIL b2b_latency got %0d periods want 2 of %0d", low_q.size(), exp_low_q[0]);
    end
    $display("back_to_back 11/01 0C/04 frames=%s", q_str(ev_q));
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] a, d;
    a = 8'($urandom); a[2] = 1'b0; d = 8'($urandom);
    clear_all();
    @(negedge clk);
    bus.start = 1'b1; bus.address = a; bus.data = d; bus.rw = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    // bit 5 of byte 1 starts at quarter 2+36+20; land inside its second quarter
    repeat (59 * QTR + QTR / 2) @(posedge clk);
    #2;
    n_vec++; if (bus.ready !== 1'b0 || bus.SIOC_oe !== 1'b1 || bus.SIOD_oe !== 1'b1) begin
      n_err++; $display("FAIL mid_state got ready=%b sioc=%b siod=%b want 0 1 1", bus.ready, bus.SIOC_oe, bus.SIOD_oe);
    end
    rst = 1'b1;
    #1;
    n_vec++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready got %b want 1", bus.ready); end
    n_vec++; if (bus.SIOC_oe !== 1'b0) begin n_err++; $display("FAIL async_rst_sioc got %b want 0", bus.SIOC_oe); end
    n_vec++; if (bus.SIOD_oe !== 1'b0) begin n_err++; $display("FAIL async_rst_siod got %b want 0", bus.SIOD_oe); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_rd = 8'h00;
    repeat (3) @(negedge clk);
    clear_all();
    a = 8'($urandom); d = 8'($urandom);
    model_cmd(a, d, 1'b0);
    issue(a, d, 1'b0);
    wait_idle(ok);
    n_vec++; if (!ok || q_str(ev_q) != q_str(exp_q)) begin
      n_err++; $display("FAIL post_rst_frame got %s want %s", q_str(ev_q), q_str(exp_q));
    end
    n_vec++; if (low_q.size() != 1 || low_q[0] != exp_low_q[0]) begin
      n_err++; $display("FAIL post_rst_latency got %0d want %0d", (low_q.size() > 0) ? low_q[0] : -1, exp_low_q[0]);
    end
    $display("reset mid-frame then write addr=%h data=%h frame=%s", a, d, q_str(ev_q));
  endtask

  task automatic test_read();
    bit ok;
    logic [7:0] a, d;
    a = READ_BUILD ? 8'h0A : 8'($urandom);
    d = 8'($urandom);
    clear_all();
    model_cmd(a, d, 1'b1);
    issue(a, d, 1'b1);
    wait_idle(ok);
    n_vec++; if (!ok || q_str(ev_q) != q_str(exp_q)) begin
      n_err++; $display("FAIL rw1_frame got %s want %s", q_str(ev_q), q_str(exp_q));
    end
    n_vec++; if (low_q.size() != 1 || low_q[0] != exp_low_q[0]) begin
      n_err++; $display("FAIL rw1_latency got %0d want %0d", (low_q.size() > 0) ? low_q[0] : -1, exp_low_q[0]);
    end
    n_vec++; if (bus.read_data !== exp_rd) begin n_err++; $display("FAIL rw1_read_data got %h want %h", bus.read_data, exp_rd); end
    $display("rw=1 addr=%h frame=%s read_data=%h", a, q_str(ev_q), bus.read_data);
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] a, d;
    logic r;
    for (int n = 0; n < 2; n++) begin
      a = 8'($urandom); d = 8'($urandom); r = 1'($urandom_range(0, 1));
      clear_all();
      model_cmd(a, d, r);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      issue(a, d, r);
      wait_idle(ok);
      n_vec++; if (!ok || q_str(ev_q) != q_str(exp_q)) begin
        n_err++; $display("FAIL random_frame got %s want %s", q_str(ev_q), q_str(exp_q));
      end
      n_vec++; if (low_q.size() != 1 || low_q[0] != exp_low_q[0] || bus.read_data !== exp_rd) begin
        n_err++; $display("FAIL random_timing got low=%0d rd=%h want low=%0d rd=%h",
                          (low_q.size() > 0) ? low_q[0] : -1, bus.read_data, exp_low_q[0], exp_rd);
      end
      $display("random cmd addr=%h data=%h rw=%b frame=%s", a, d, r, q_str(ev_q));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.address = 8'h00; bus.data = 8'h00; bus.rw = 1'b0;
    test_reset();
    test_write_basic();
    test_ignore_mid();
    test_back_to_back();
    test_reset_mid();
    test_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
